// File: rtl/trace_tx_pkg.sv
// rtl/trace_tx_pkg.sv - shared constants, FSM type and width helpers for trace_tx
package trace_tx_pkg;

    // Port width codes; 2'b00 is treated like W1.
    localparam logic [1:0] W1 = 2'b01;
    localparam logic [1:0] W2 = 2'b10;
    localparam logic [1:0] W4 = 2'b11;

    localparam logic [7:0] SYNC_FF  = 8'hFF;
    localparam logic [7:0] SYNC_END = 8'h7F;

    typedef enum logic [1:0] {
        SYNC_FULL = 2'd0,
        SYNC_HALF = 2'd1,
        DATA      = 2'd2
    } state_t;

    function automatic logic [3:0] slots_per_byte(input logic [1:0] w);
        case (w)
            W4:      return 4'd2;
            W2:      return 4'd4;
            W1:      return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/trace_tx_shifter.sv
// rtl/trace_tx_shifter.sv - serialises one byte into 1/2/4-bit slots, LSB first
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   load         take load_byte/load_width this edge; first slot appears at once
//   load_byte    byte to serialise
//   load_width   width code, latched for the whole byte
//   dout         current slot, unused pins 0
//   active       a byte is being presented
//   last         the slot on dout is the last one of the byte
module trace_tx_shifter
    import trace_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic [1:0] load_width,
    output logic [3:0] dout,
    output logic       active,
    output logic       last
);

    logic [7:0] rem;
    logic [1:0] width_q;
    logic [3:0] left;

    function automatic logic [3:0] slot_of(input logic [7:0] d, input logic [1:0] w);
        case (w)
            W4:      return d[3:0];
            W2:      return {2'b00, d[1:0]};
            default: return {3'b000, d[0]};
        endcase
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] d, input logic [1:0] w);
        case (w)
            W4:      return {4'b0000, d[7:4]};
            W2:      return {2'b00, d[7:2]};
            default: return {1'b0, d[7:1]};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= 4'd0;
            rem     <= 8'd0;
            width_q <= 2'd0;
            left    <= 4'd0;
            active  <= 1'b0;
        end else if (load) begin
            dout    <= slot_of(load_byte, load_width);
            rem     <= shift_out(load_byte, load_width);
            width_q <= load_width;
            left    <= slots_per_byte(load_width) - 4'd1;
            active  <= 1'b1;
        end else if (active && left != 4'd0) begin
            dout    <= slot_of(rem, width_q);
            rem     <= shift_out(rem, width_q);
            left    <= left - 4'd1;
        end else begin
            dout    <= 4'd0;
            active  <= 1'b0;
        end
    end

    assign last = active && (left == 4'd0);

endmodule

// File: rtl/trace_tx.sv
// rtl/trace_tx.sv - parallel trace-port transmitter with full/halfword sync insertion
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   width        port width code (00/01 = 1-bit, 10 = 2-bit, 11 = 4-bit)
//   txByte       byte to send, qualified by txValid, accepted when txReady
//   txValid      txByte valid
//   txReady      one-byte hold buffer is free
//   traceDout    trace data pins, one slot per clk
//   traceClkOut  trace clock, toggles every clk
//   syncing      a sync byte is on the pins
//   busy         a data byte is held or being shifted
module trace_tx
    import trace_tx_pkg::*;
#(
    parameter int SYNC_INTERVAL = 1024,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] width,
    input  logic [7:0] txByte,
    input  logic       txValid,
    output logic       txReady,
    output logic [3:0] traceDout,
    output logic       traceClkOut,
    output logic       syncing,
    output logic       busy
);

    state_t             state, state_n;
    logic [1:0]         idx, idx_n;
    logic               hold_full;
    logic [7:0]         hold_byte;
    logic [CNT_W-1:0]   sync_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               full_pending;
    logic               out_en;
    logic               clk_q;
    logic               syncing_q;
    logic               sh_active, sh_last, boundary, seq_more;
    logic               accept, start_data, start_full;
    logic [7:0]         load_byte;
    logic               load_sync;

    // out_en keeps txReady low in the cycle right after reset so that
    // every output reads 0 there.
    assign txReady  = !hold_full && !rst && out_en;
    assign accept   = txValid && txReady;
    assign boundary = !sh_active || sh_last;
    // A sync sequence still has bytes to go; only meaningful while shifting.
    assign seq_more = sh_active &&
                      ((state == SYNC_FULL && idx != 2'd3) ||
                       (state == SYNC_HALF && idx == 2'd0));
    assign cnt_inc  = sync_cnt + 1'b1;

    trace_tx_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (boundary),
        .load_byte  (load_byte),
        .load_width (width),
        .dout       (traceDout),
        .active     (sh_active),
        .last       (sh_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC_FULL;
            idx   <= 2'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        start_data = 1'b0;
        start_full = 1'b0;
        if (boundary) begin
            if (seq_more) begin
                idx_n = idx + 2'd1;
            end else if (full_pending) begin
                state_n    = SYNC_FULL;
                idx_n      = 2'd0;
                start_full = 1'b1;
            end else if (hold_full) begin
                state_n    = DATA;
                idx_n      = 2'd0;
                start_data = 1'b1;
            end else begin
                state_n = SYNC_HALF;
                idx_n   = 2'd0;
            end
        end
    end

    // The byte to load is decided by where the FSM lands: the final byte of
    // either sync sequence is 7F, every other sync byte is FF.
    always_comb begin
        load_byte = SYNC_FF;
        load_sync = 1'b1;
        if (state_n == DATA) begin
            load_byte = hold_byte;
            load_sync = 1'b0;
        end else if ((state_n == SYNC_FULL && idx_n == 2'd3) ||
                     (state_n == SYNC_HALF && idx_n == 2'd1)) begin
            load_byte = SYNC_END;
        end
    end

    // An accept and a drain in the same edge keeps the buffer full with the
    // new byte; the old one has already been handed to the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_byte <= 8'd0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_byte <= txByte;
        end else if (start_data) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt     <= '0;
            full_pending <= 1'b1;
        end else if (start_full) begin
            full_pending <= 1'b0;
        end else if (start_data) begin
            if (SYNC_INTERVAL != 0 && cnt_inc == CNT_W'(SYNC_INTERVAL)) begin
                sync_cnt     <= '0;
                full_pending <= 1'b1;
            end else begin
                sync_cnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q     <= 1'b0;
            out_en    <= 1'b0;
            syncing_q <= 1'b0;
        end else begin
            clk_q  <= ~clk_q;
            out_en <= 1'b1;
            if (boundary) begin
                syncing_q <= load_sync;
            end
        end
    end

    assign traceClkOut = clk_q;
    assign syncing     = syncing_q;
    assign busy        = hold_full || (state == DATA);

endmodule
